// File: rtl/cache_pkg.sv
// Shared constants and types for the cache miss-fill controller.
package cache_pkg;

    localparam int WORDS_PER_BLOCK = 8;   // 16-bit words per cache block
    localparam int BLOCK_BYTES     = 16;  // bytes per cache block
    localparam int WORD_OFF_W      = 3;   // word offset bits within a block
    localparam int BYTE_OFF_W      = 4;   // byte offset bits within a block
    localparam int MEM_LATENCY     = 4;   // request-to-data latency of the bench memory model

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_fill_counter.sv
// Saturating up-counter with synchronous clear, increment enable and
// asynchronous active-low reset. Stops counting once it reaches MAX.
module fill_counter #(
    parameter int W   = 4,
    parameter int MAX = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    localparam logic [W-1:0] CNT_MAX = W'(MAX);

    logic [W-1:0] cnt_reg;

    // Count register: clear has priority over increment; hold at CNT_MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (inc && (cnt_reg != CNT_MAX)) begin
            cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign cnt = cnt_reg;

endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss-fill controller: on a miss, fetches the whole block from a
// pipelined fixed-latency memory, streams the returned words into the cache
// data array and writes the tag with the last word. fsm_busy is high for the
// whole fill.
// Optional feature macro: CRITICAL_WORD_FIRST_EN -- when defined, requests
// and fills start at the missed word and wrap around within the block.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = cache_pkg::WORDS_PER_BLOCK,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               miss_detected,
    input  logic [ADDR_W-1:0]                  miss_address,
    input  logic                               memory_data_valid,
    input  logic [DATA_W-1:0]                  memory_data,
    output logic                               fsm_busy,
    output logic                               mem_read,
    output logic [ADDR_W-1:0]                  memory_address,
    output logic                               write_data_array,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic [DATA_W-1:0]                  fill_data,
    output logic                               write_tag_array
);

    import cache_pkg::*;

    // Words are 16-bit, so the byte offset is one bit wider than the word offset.
    localparam int WOFF_W = $clog2(WORDS_PER_BLOCK);
    localparam int BOFF_W = WOFF_W + 1;
    localparam int CNT_W  = WOFF_W + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

    fill_state_t        state_reg, state_next;
    logic [ADDR_W-1:0]  base_reg, base_next;
    logic [WOFF_W-1:0]  w0_reg, w0_next;
    logic [WOFF_W-1:0]  miss_word;
    logic [CNT_W-1:0]   req_cnt, rsp_cnt;
    logic               in_idle, req_active, rsp_write, last_rsp;
    logic [WOFF_W-1:0]  req_word, rsp_word;
    logic               unused_addr_bits;

`ifdef CRITICAL_WORD_FIRST_EN
    // Start the fill at the word that actually missed.
    assign miss_word = miss_address[BOFF_W-1:1];
`else
    // Always fill in ascending order from word 0.
    assign miss_word = '0;
`endif

    // Byte-offset bits never feed the block base.
    assign unused_addr_bits = ^miss_address[BOFF_W-1:0];

    assign in_idle    = (state_reg == IDLE);
    assign req_active = (state_reg == FILL) && (req_cnt < CNT_FULL);
    assign rsp_write  = (state_reg == FILL) && memory_data_valid;
    assign last_rsp   = rsp_write && (rsp_cnt == CNT_LAST);

    // Offsets wrap modulo the block size by virtue of the WOFF_W-bit sum,
    // so requests never carry into the block address bits.
    assign req_word = w0_reg + req_cnt[WOFF_W-1:0];
    assign rsp_word = w0_reg + rsp_cnt[WOFF_W-1:0];

    // Both counters are held at zero whenever no fill is in progress.
    fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_req_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_idle),
        .inc   (req_active),
        .cnt   (req_cnt)
    );

    fill_counter #(.W(CNT_W), .MAX(WORDS_PER_BLOCK)) u_rsp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (in_idle),
        .inc   (rsp_write),
        .cnt   (rsp_cnt)
    );

    // State, latched block base and first-word offset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            base_reg  <= '0;
            w0_reg    <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
            w0_reg    <= w0_next;
        end
    end

    // Next-state logic and outputs; outputs are idle-zero outside a fill.
    always_comb begin
        state_next       = state_reg;
        base_next        = base_reg;
        w0_next          = w0_reg;
        fsm_busy         = 1'b0;
        mem_read         = 1'b0;
        memory_address   = '0;
        write_data_array = 1'b0;
        fill_word        = '0;
        fill_data        = '0;
        write_tag_array  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (miss_detected) begin
                    state_next = FILL;
                    base_next  = {miss_address[ADDR_W-1:BOFF_W], {BOFF_W{1'b0}}};
                    w0_next    = miss_word;
                end
            end
            FILL: begin
                fsm_busy = 1'b1;
                mem_read = req_active;
                if (req_active) begin
                    memory_address = {base_reg[ADDR_W-1:BOFF_W], req_word, 1'b0};
                end
                write_data_array = rsp_write;
                if (rsp_write) begin
                    fill_word = rsp_word;
                    fill_data = memory_data;
                end
                write_tag_array = last_rsp;
                if (last_rsp) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Directed testbench for cache_fill_fsm with a fixed-latency memory model.
// Prints one line per fill transaction and a final pass summary.
module tb_cache_fill_fsm;

    import cache_pkg::*;

    localparam int L = MEM_LATENCY;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        miss_detected = 1'b0;
    logic [15:0] miss_address = 16'h0;
    logic        memory_data_valid = 1'b0;
    logic [15:0] memory_data = 16'h0;
    logic        fsm_busy;
    logic        mem_read;
    logic [15:0] memory_address;
    logic        write_data_array;
    logic [2:0]  fill_word;
    logic [15:0] fill_data;
    logic        write_tag_array;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory return pipeline: entry 0 holds the newest request.
    logic        pv [L];
    logic [15:0] pa [L];

    cache_fill_fsm dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .fsm_busy          (fsm_busy),
        .mem_read          (mem_read),
        .memory_address    (memory_address),
        .write_data_array  (write_data_array),
        .fill_word         (fill_word),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return a ^ 16'hA5A5;
    endfunction

    // Sample the request at the negedge, cross one rising edge, then update
    // the memory return inputs and settle back to the next negedge.
    task automatic advance();
        logic        rv;
        logic [15:0] ra;
        rv = mem_read;
        ra = memory_address;
        @(posedge clk);
        #1;
        for (int i = L - 1; i > 0; i--) begin
            pv[i] = pv[i-1];
            pa[i] = pa[i-1];
        end
        pv[0] = rv;
        pa[0] = ra;
        memory_data_valid = pv[L-1];
        memory_data       = pv[L-1] ? mem_word(pa[L-1]) : 16'h0;
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  {31'b0, fsm_busy}, 32'd0);
        check({tag, "_rd"},    {31'b0, mem_read}, 32'd0);
        check({tag, "_addr"},  {16'b0, memory_address}, 32'd0);
        check({tag, "_wr"},    {31'b0, write_data_array}, 32'd0);
        check({tag, "_word"},  {29'b0, fill_word}, 32'd0);
        check({tag, "_data"},  {16'b0, fill_data}, 32'd0);
        check({tag, "_tag"},   {31'b0, write_tag_array}, 32'd0);
    endtask

    // One miss/fill transaction. inject_k: FILL cycle with a stray miss to
    // 0x4000; abort_k: FILL cycle where reset is pulsed; tail_miss: raise a
    // miss to tail_addr in the completion cycle and keep it asserted.
    task automatic do_fill(input logic [15:0] maddr, input int inject_k, input int abort_k,
                           input logic tail_miss, input logic [15:0] tail_addr);
        logic [15:0] base;
        logic [15:0] ea;
        int          w0;
        int          rw;
        base = {maddr[15:4], 4'h0};
`ifdef CRITICAL_WORD_FIRST_EN
        w0 = int'(maddr[3:1]);
`else
        w0 = 0;
`endif
        miss_detected = 1'b1;
        miss_address  = maddr;
        check("busy_in_miss_cycle", {31'b0, fsm_busy}, 32'd0);
        advance();
        miss_detected = 1'b0;
        miss_address  = 16'h0;
        for (int k = 0; k < 8 + L; k++) begin
            if (k == abort_k) begin
                rst_n = 1'b0;
                #1;
                check_all_zero("reset_mid_fill");
                advance();
                advance();
                rst_n = 1'b1;
                for (int j = 0; j < L + 2; j++) begin
                    check("late_valid_no_write", {31'b0, write_data_array}, 32'd0);
                    check("late_valid_idle", {31'b0, fsm_busy}, 32'd0);
                    advance();
                end
                $display("fill miss=0x%04h base=0x%04h aborted by reset in FILL cycle %0d", maddr, base, k);
                return;
            end
            if (k == inject_k) begin
                miss_detected = 1'b1;
                miss_address  = 16'h4000;
            end
            if (k == 8 + L - 1 && tail_miss) begin
                miss_detected = 1'b1;
                miss_address  = tail_addr;
            end
            ea = (k < 8) ? (base | 16'(((w0 + k) % 8) * 2)) : 16'h0;
            check("fill_busy", {31'b0, fsm_busy}, 32'd1);
            check("req_valid", {31'b0, mem_read}, (k < 8) ? 32'd1 : 32'd0);
            check("req_addr", {16'b0, memory_address}, {16'b0, ea});
            check("wr_valid", {31'b0, write_data_array}, (k >= L) ? 32'd1 : 32'd0);
            if (k >= L) begin
                rw = (w0 + k - L) % 8;
                check("wr_word", {29'b0, fill_word}, 32'(rw));
                check("wr_data", {16'b0, fill_data},
                      {16'b0, mem_word(base | 16'(rw * 2))});
            end
            check("tag_write", {31'b0, write_tag_array}, (k == 8 + L - 1) ? 32'd1 : 32'd0);
            advance();
            if (k == inject_k) begin
                miss_detected = 1'b0;
                miss_address  = 16'h0;
            end
        end
        check("idle_after_fill", {31'b0, fsm_busy}, 32'd0);
        check("no_req_after_fill", {31'b0, mem_read}, 32'd0);
        check("no_wr_after_fill", {31'b0, write_data_array}, 32'd0);
        $display("fill miss=0x%04h base=0x%04h first_word=%0d completed", maddr, base, w0);
    endtask

    initial begin
        for (int i = 0; i < L; i++) begin
            pv[i] = 1'b0;
            pa[i] = 16'h0;
        end
        #2;
        check_all_zero("reset_state");
        @(negedge clk);
        advance();
        rst_n = 1'b1;
        advance();
        check_all_zero("idle_after_reset");

        // Basic fill
        do_fill(16'h1236, -1, -1, 1'b0, 16'h0);
        // Stray miss during FILL cycle 3
        do_fill(16'h1236, 3, -1, 1'b0, 16'h0);
        // Top-of-memory block, no carry out of the block
        do_fill(16'hFFFA, -1, -1, 1'b0, 16'h0);
        // Reset in FILL cycle 6, then a clean fill
        do_fill(16'h1236, -1, 6, 1'b0, 16'h0);
        do_fill(16'h0020, -1, -1, 1'b0, 16'h0);
        // Miss held through completion cycle: accepted only once back in IDLE
        do_fill(16'h2468, -1, -1, 1'b1, 16'h5552);
        do_fill(16'h5552, -1, -1, 1'b0, 16'h0);
        // Mid-block miss (critical word first ordering when enabled)
        do_fill(16'h123A, -1, -1, 1'b0, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling controller for the L1 instruction and data caches. It sits between the CPU core's memory ports and the shared multicycle main memory, with one instance per cache. On a cache miss it fetches the whole 16-byte block (8 x 16-bit words) over a pipelined memory interface with fixed latency. It then streams the words into the cache data array, writes the tag, and holds the pipeline stalled via fsm_busy until the fill completes.

Parameters:
WORDS_PER_BLOCK, 8, words per cache block; must be a power of two.
ADDR_W, 16, byte-address width.
DATA_W, 16, word width.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
rst_n  in  1  asynchronous active-low reset.
miss_detected  in  1  cache lookup missed this cycle; sampled only in IDLE.
miss_address  in  ADDR_W  byte address of the missing access; valid with miss_detected.
memory_data_valid  in  1  memory_data carries a returned word this cycle.
memory_data  in  DATA_W  returned memory word.
fsm_busy  out  1  high while a fill is in progress (state FILL).
mem_read  out  1  read request to main memory this cycle.
memory_address  out  ADDR_W  byte address of the current request.
write_data_array  out  1  write fill_data into data-array word fill_word.
fill_word  out  log2(WORDS_PER_BLOCK)  word offset within the block being written.
fill_data  out  DATA_W  word to write; equals memory_data.
write_tag_array  out  1  write the tag/valid for the block of the latched miss_address.

Behaviour:
- States: IDLE, FILL. Reset (asynchronous, rst_n low) forces IDLE, both counters to 0, latched address to 0.
- Reset values of outputs: fsm_busy=0, mem_read=0, write_data_array=0, write_tag_array=0, memory_address=0, fill_word=0, fill_data=0.
- Accepting a miss: in IDLE, miss_detected=1 at a rising edge latches base = {miss_address[ADDR_W-1:4], 4'b0} and enters FILL.
- No stall in the miss cycle itself: fsm_busy is a registered state output. The cache ORs in miss_detected to stall that cycle.
- Request side (FILL): req_cnt counts 0..7.
  - mem_read=1 while req_cnt < 8; memory_address = base + 2*req_cnt.
  - req_cnt increments on each request and saturates at 8; mem_read=0 afterwards.
  - One request per cycle, no backpressure.
- Response side (FILL): rsp_cnt counts 0..7.
  - Each memory_data_valid=1 asserts write_data_array=1 combinationally, with fill_word = rsp_cnt and fill_data = memory_data.
  - rsp_cnt increments on each such cycle.
- Completion:
  - The cycle with rsp_cnt=7 and valid=1 also asserts write_tag_array=1.
  - The next state is IDLE and fsm_busy drops next cycle.
- Latency: with memory latency L, a fill occupies FILL for 8+L cycles. Example: L=4 gives 12 FILL cycles.
- Ignored inputs:
  - memory_data_valid in IDLE: no write.
  - miss_detected while in FILL.
  - miss_detected in the completion cycle: it is not accepted until IDLE.
- Wrap-around: block offset math is modulo 16 bytes, so addresses never leave the block. A block at 0xFFF0 fetches 0xFFF0..0xFFFE without carry into other bits.
- Reset mid-fill: immediate return to IDLE; any subsequently returning valid data is ignored.

Optional Feature:
CRITICAL_WORD_FIRST_EN
- Defined: the first request is the missed word, w0 = miss_address[3:1].
  - Requests go to base + 2*((w0 + req_cnt) mod 8).
  - fill_word = (w0 + rsp_cnt) mod 8, wrapping 7 to 0.
  - Tag is still written with the 8th returned word.
- Undefined: requests and fills start at word 0 in ascending order.

Decomposition:
- Package cache_pkg:
  - WORDS_PER_BLOCK, BLOCK_BYTES=16, WORD_OFF_W=3, BYTE_OFF_W=4.
  - Typedef fill_state_t {IDLE, FILL}.
  - MEM_LATENCY=4, for the bench memory model.
- Sub-module fill_counter: a 4-bit saturating up-counter with synchronous clear, increment enable and asynchronous active-low reset. Instantiated twice, for req_cnt and rsp_cnt.

Test Plan:
1. Basic fill: reset, miss at 0x1236, memory latency 4.
   - mem_read high 8 cycles with addresses 0x1230,0x1232,...,0x123E.
   - Eight write_data_array pulses with fill_word 0..7 and data matching memory.
   - write_tag_array with word 7; fsm_busy high exactly 12 cycles.
2. Miss during fill: assert miss_detected at 0x4000 in FILL cycle 3 -> ignored; addresses stay in block 0x1230.
3. Top-of-memory block: miss at 0xFFFA -> addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
4. Reset mid-fill: rst_n low in FILL cycle 6 -> all outputs 0 asynchronously; late valid data causes no write; next miss at 0x0020 fills normally.
5. Back-to-back misses: miss asserted in the cycle after completion -> second fill starts immediately with the correct new base.
6. With CRITICAL_WORD_FIRST_EN: miss at 0x123A (w0=5).
   - Requests in order 0x123A,0x123C,0x123E,0x1230..0x1238.
   - fill_word sequence 5,6,7,0,1,2,3,4; tag written with word 4.
